// File: rtl/some_module.sv
// -----------------------------------------------------------------------------
// some_module -- block accumulator
//
// Adds up N = SOME_OTHER_INT_PARAM consecutive 8-bit samples and presents each
// block sum on a valid/ready output port.
//
// Samples are unsigned or two's-complement, selected by SOME_BIT_PARAM.
// The accumulator is OUT_W = 8 + $clog2(N) bits wide, so it never overflows.
//
// Each completed sum is held until the consumer takes it. A new block may
// complete in the same edge that the previous sum drains.
//
// Parameters
//   SOME_BIT_PARAM        1 = two's-complement samples, 0 = unsigned
//   SOME_OTHER_INT_PARAM  samples per block (N), must be >= 1
//
// Optional feature
//   Define SOME_MODULE_CLEAR_EN to add the 'clear' input. When clear is high,
//   it zeroes the accumulator and sample count. It discards any sample accepted
//   in that cycle. It leaves the output register alone.
//
// Ports
//   clk         single clock, rising edge
//   rst         synchronous, active-high reset
//   clear       (SOME_MODULE_CLEAR_EN only) abandon the current partial block
//   in_valid    a sample is offered
//   in_data     8-bit sample
//   in_ready    a sample can be accepted this cycle
//   out_valid   a block sum is held
//   out_data    block sum, OUT_W bits
//   out_ready   consumer takes the sum
//   sample_cnt  samples accepted so far in the current block
// -----------------------------------------------------------------------------
module some_module #(
  parameter bit SOME_BIT_PARAM       = 1'b0,
  parameter int SOME_OTHER_INT_PARAM = 4,
  localparam int OUT_W = 8 + $clog2(SOME_OTHER_INT_PARAM),
  localparam int CNT_W = ($clog2(SOME_OTHER_INT_PARAM) < 1) ? 1
                                                            : $clog2(SOME_OTHER_INT_PARAM)
) (
  input  logic             clk,
  input  logic             rst,
`ifdef SOME_MODULE_CLEAR_EN
  input  logic             clear,
`endif
  input  logic             in_valid,
  input  logic [7:0]       in_data,
  output logic             in_ready,
  output logic             out_valid,
  output logic [OUT_W-1:0] out_data,
  input  logic             out_ready,
  output logic [CNT_W-1:0] sample_cnt
);

  localparam int N = SOME_OTHER_INT_PARAM;

  if (N < 1) begin : g_bad_n
    $error("some_module: SOME_OTHER_INT_PARAM must be at least 1");
  end

  // Index of the sample that closes a block. For N=1 this is always 0, so
  // every accepted sample completes its own block.
  localparam logic [CNT_W-1:0] LAST_IDX = CNT_W'(N - 1);

  logic             clr;
  logic             accept;
  logic             last;
  logic             complete;
  logic [OUT_W-1:0] acc;
  logic [OUT_W-1:0] ext;
  logic [OUT_W-1:0] sum;

`ifdef SOME_MODULE_CLEAR_EN
  assign clr = clear;
`else
  assign clr = 1'b0;
`endif

  // Widen the sample to the accumulator width. A size cast of a signed
  // operand sign-extends, and a size cast of an unsigned operand zero-extends.
  if (SOME_BIT_PARAM) begin : g_signed
    assign ext = OUT_W'($signed(in_data));
  end else begin : g_unsigned
    assign ext = OUT_W'(in_data);
  end

  // Plain modular addition is correct for both signednesses. OUT_W is wide
  // enough that the true block sum always fits.
  assign sum = acc + ext;

  // Input is blocked only while a sum is held that nobody is taking.
  assign in_ready = !out_valid || out_ready;
  assign accept   = in_valid && in_ready;
  assign last     = (sample_cnt == LAST_IDX);
  // A sample accepted in a clearing cycle is dropped, so it cannot close a block.
  assign complete = accept && last && !clr;

  // Accumulator and sample counter.
  // NOTE: state registers use non-blocking assignments so every register in
  // the block samples the pre-edge values of its neighbours.
  always_ff @(posedge clk) begin
    if (rst) begin
      acc        <= '0;
      sample_cnt <= '0;
    end else if (clr) begin
      acc        <= '0;
      sample_cnt <= '0;
    end else if (accept) begin
      if (last) begin
        acc        <= '0;
        sample_cnt <= '0;
      end else begin
        acc        <= sum;
        sample_cnt <= sample_cnt + 1'b1;
      end
    end
  end

  // Output register. A completing block takes priority over draining. This
  // keeps out_valid high with no gap when a drain and a completion coincide.
  always_ff @(posedge clk) begin
    if (rst) begin
      out_valid <= 1'b0;
      out_data  <= '0;
    end else if (complete) begin
      out_valid <= 1'b1;
      out_data  <= sum;
    end else if (out_valid && out_ready) begin
      out_valid <= 1'b0;
    end
  end

endmodule

// File: tb/tb_some_module.sv
// -----------------------------------------------------------------------------
// tb_some_module -- directed self-checking bench for some_module
//
// Instances
//   dut_a    N=4, unsigned
//   dut_s18  N=18, signed
//   dut_u18  N=18, unsigned
//   dut_c    N=1, signed
//
// Inputs are driven 1 time unit after a rising edge, and outputs are checked
// at that same point.
// -----------------------------------------------------------------------------
module tb_some_module;

  logic clk = 1'b0;
  logic rst;
  logic clear;

  always #5 clk = ~clk;

  // N=4 unsigned
  logic       in_valid_a, out_ready_a, in_ready_a, out_valid_a;
  logic [7:0] in_data_a;
  logic [9:0] out_data_a;
  logic [1:0] sample_cnt_a;

  // N=18 signed / unsigned, sharing stimulus
  logic        in_valid_b, out_ready_b;
  logic [7:0]  in_data_b;
  logic        in_ready_s, out_valid_s, in_ready_u, out_valid_u;
  logic [12:0] out_data_s, out_data_u;
  logic [4:0]  sample_cnt_s, sample_cnt_u;

  // N=1 signed
  logic       in_valid_c, out_ready_c, in_ready_c, out_valid_c;
  logic [7:0] in_data_c, out_data_c;
  logic [0:0] sample_cnt_c;

  some_module #(.SOME_BIT_PARAM(1'b0), .SOME_OTHER_INT_PARAM(4)) dut_a (
    .clk(clk), .rst(rst),
`ifdef SOME_MODULE_CLEAR_EN
    .clear(clear),
`endif
    .in_valid(in_valid_a), .in_data(in_data_a), .in_ready(in_ready_a),
    .out_valid(out_valid_a), .out_data(out_data_a), .out_ready(out_ready_a),
    .sample_cnt(sample_cnt_a)
  );

  some_module #(.SOME_BIT_PARAM(1'b1), .SOME_OTHER_INT_PARAM(18)) dut_s18 (
    .clk(clk), .rst(rst),
`ifdef SOME_MODULE_CLEAR_EN
    .clear(1'b0),
`endif
    .in_valid(in_valid_b), .in_data(in_data_b), .in_ready(in_ready_s),
    .out_valid(out_valid_s), .out_data(out_data_s), .out_ready(out_ready_b),
    .sample_cnt(sample_cnt_s)
  );

  some_module #(.SOME_BIT_PARAM(1'b0), .SOME_OTHER_INT_PARAM(18)) dut_u18 (
    .clk(clk), .rst(rst),
`ifdef SOME_MODULE_CLEAR_EN
    .clear(1'b0),
`endif
    .in_valid(in_valid_b), .in_data(in_data_b), .in_ready(in_ready_u),
    .out_valid(out_valid_u), .out_data(out_data_u), .out_ready(out_ready_b),
    .sample_cnt(sample_cnt_u)
  );

  some_module #(.SOME_BIT_PARAM(1'b1), .SOME_OTHER_INT_PARAM(1)) dut_c (
    .clk(clk), .rst(rst),
`ifdef SOME_MODULE_CLEAR_EN
    .clear(1'b0),
`endif
    .in_valid(in_valid_c), .in_data(in_data_c), .in_ready(in_ready_c),
    .out_valid(out_valid_c), .out_data(out_data_c), .out_ready(out_ready_c),
    .sample_cnt(sample_cnt_c)
  );

  int checks   = 0;
  int failures = 0;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Offer one sample to dut_a and let one edge pass.
  task automatic push_a(input logic [7:0] d);
    in_valid_a = 1'b1;
    in_data_a  = d;
    tick();
  endtask

  initial begin
    rst = 1'b1; clear = 1'b0;
    in_valid_a = 1'b0; in_data_a = '0; out_ready_a = 1'b0;
    in_valid_b = 1'b0; in_data_b = '0; out_ready_b = 1'b1;
    in_valid_c = 1'b0; in_data_c = '0; out_ready_c = 1'b1;
    tick();
    tick();

    // Reset state
    check("rst_out_valid", out_valid_a, 0);
    check("rst_out_data", out_data_a, 0);
    check("rst_sample_cnt", sample_cnt_a, 0);
    check("rst_in_ready", in_ready_a, 1);
    rst = 1'b0;

    // N=4 unsigned, consumer stalled: 1+2+3+4 = 10 held
    push_a(8'd1);
    check("cnt_after_1", sample_cnt_a, 1);
    push_a(8'd2);
    push_a(8'd3);
    check("cnt_after_3", sample_cnt_a, 3);
    check("no_valid_mid_block", out_valid_a, 0);
    push_a(8'd4);
    check("blk1_valid", out_valid_a, 1);
    check("blk1_data", out_data_a, 10);
    check("blk1_cnt_wrap", sample_cnt_a, 0);
    check("blk1_in_ready_low", in_ready_a, 0);

    // Samples offered while stalled have no effect
    push_a(8'd5);
    push_a(8'd5);
    check("stall_cnt", sample_cnt_a, 0);
    check("stall_data", out_data_a, 10);
    check("stall_valid", out_valid_a, 1);

    // Drain 10 and accept 5 in the same edge, then 6,7,8 -> 26
    out_ready_a = 1'b1;
    #1;
    check("in_ready_comb", in_ready_a, 1);
    push_a(8'd5);
    check("drain_valid_low", out_valid_a, 0);
    check("drain_cnt", sample_cnt_a, 1);
    push_a(8'd6);
    push_a(8'd7);
    push_a(8'd8);
    check("blk2_valid", out_valid_a, 1);
    check("blk2_data", out_data_a, 26);

    // Reset mid-block (3+4 = 7 partial) discards both partial and pending state
    push_a(8'd3);
    push_a(8'd4);
    check("partial_cnt", sample_cnt_a, 2);
    rst = 1'b1;
    push_a(8'd9);
    rst = 1'b0;
    check("midrst_cnt", sample_cnt_a, 0);
    check("midrst_valid", out_valid_a, 0);
    check("midrst_data", out_data_a, 0);
    check("midrst_in_ready", in_ready_a, 1);
    for (int i = 0; i < 4; i++) push_a(8'd1);
    check("post_rst_valid", out_valid_a, 1);
    check("post_rst_data", out_data_a, 4);

`ifdef SOME_MODULE_CLEAR_EN
    // Clear after 3 samples drops them; the output register is untouched
    for (int i = 0; i < 3; i++) push_a(8'd5);
    check("pre_clear_cnt", sample_cnt_a, 3);
    clear = 1'b1;
    push_a(8'd5);
    clear = 1'b0;
    check("clear_cnt", sample_cnt_a, 0);
    check("clear_keeps_data", out_data_a, 4);
    check("clear_keeps_valid", out_valid_a, 0);
    push_a(8'd1);
    push_a(8'd2);
    push_a(8'd3);
    push_a(8'd4);
    check("after_clear_data", out_data_a, 10);
    check("after_clear_valid", out_valid_a, 1);
`endif
    in_valid_a = 1'b0;

    // N=18: eighteen samples of 8'hFF, signed and unsigned
    in_valid_b = 1'b1;
    in_data_b  = 8'hFF;
    for (int i = 0; i < 17; i++) tick();
    check("s18_cnt_17", sample_cnt_s, 17);
    check("s18_not_valid", out_valid_s, 0);
    tick();
    in_valid_b = 1'b0;
    check("s18_valid", out_valid_s, 1);
    check("s18_data", out_data_s, 13'h1FEE);
    check("s18_cnt_wrap", sample_cnt_s, 0);
    check("u18_valid", out_valid_u, 1);
    check("u18_data", out_data_u, 13'h11EE);
    check("u18_cnt_wrap", sample_cnt_u, 0);
    tick();
    check("s18_drained", out_valid_s, 0);

    // N=1 signed: each sample is its own block, with back-to-back out_valid
    in_valid_c = 1'b1;
    in_data_c  = 8'h80;
    tick();
    check("n1_valid_0", out_valid_c, 1);
    check("n1_data_0", out_data_c, 8'h80);
    in_data_c = 8'h7F;
    tick();
    check("n1_b2b_valid", out_valid_c, 1);
    check("n1_b2b_data", out_data_c, 8'h7F);
    out_ready_c = 1'b0;
    in_data_c   = 8'h05;
    #1;
    check("n1_in_ready_low", in_ready_c, 0);
    tick();
    check("n1_stall_data", out_data_c, 8'h7F);
    out_ready_c = 1'b1;
    tick();
    check("n1_data_2", out_data_c, 8'h05);
    in_valid_c = 1'b0;
    tick();
    check("n1_drained", out_valid_c, 0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/some_module.md
SOME_MODULE -- requirements
Module: some_module

Interface
REQ-001 SHALL have parameter SOME_BIT_PARAM, default 0, sample signedness: 1 = two's-complement inputs, 0 = unsigned.
REQ-002 SHALL have parameter SOME_OTHER_INT_PARAM (N), default 4, samples per block; N < 1 SHALL cause an elaboration error.
REQ-003 SHALL define the localparam OUT_W = 8 + $clog2(N), so that OUT_W = 8 when N = 1.
REQ-004 SHALL have port clk, input, 1 bit, the single clock; all logic is sampled on its rising edge.
REQ-005 SHALL have port rst, input, 1 bit, with reset synchronous and active-high.
REQ-006 SHALL have port in_valid, input, 1 bit, meaning an input sample is offered.
REQ-007 SHALL have port in_data, input, 8 bits, the sample value.
REQ-008 SHALL have port in_ready, output, 1 bit, meaning a sample can be accepted this cycle.
REQ-009 SHALL have port out_valid, output, 1 bit, meaning a block sum is held.
REQ-010 SHALL have port out_data, output, OUT_W bits, the block sum.
REQ-011 SHALL have port out_ready, input, 1 bit, meaning the consumer takes the sum.
REQ-012 SHALL have port sample_cnt, output, max(1,$clog2(N)) bits, the number of samples accepted in the current block.

Function
REQ-013 SHALL accept a sample exactly when in_valid && in_ready at a clock edge.
REQ-014 SHALL drive in_ready = !out_valid || out_ready (combinational), allowing accept and drain in the same cycle.
REQ-015 SHALL extend each accepted sample to OUT_W bits, sign-extended if SOME_BIT_PARAM=1 and zero-extended if 0, before adding it to the accumulator.
REQ-016 SHALL ensure the accumulator never overflows: OUT_W holds N*255 unsigned and the range -128N..127N signed.
REQ-017 SHALL, on the Nth accepted sample, load out_data with the sum including that sample, set out_valid the next cycle, and clear the accumulator and sample_cnt to 0 in that same edge.
REQ-018 SHALL otherwise increment sample_cnt by 1 per accepted sample, holding it when no sample is accepted.
REQ-019 SHALL hold out_valid and out_data stable until out_valid && out_ready; out_valid then clears unless a new block completes in that same edge, in which case out_valid stays 1 and out_data takes the new sum.
REQ-020 SHALL, for N=1, output each accepted sample as its own extended value one cycle after acceptance.
REQ-021 SHALL let in_valid without in_ready have no effect on any state.

Reset
REQ-022 SHALL, while rst=1 at a clock edge, set the accumulator to 0, sample_cnt=0, out_valid=0, and out_data=0.
REQ-023 SHALL, on reset mid-block or with out_valid pending, discard the partial sum and the pending output; in_ready reads 1 after reset.

Configuration
REQ-024 SHALL, when SOME_MODULE_CLEAR_EN is defined, add input port clear (1 bit) that, when high at an edge, zeroes the accumulator and sample_cnt; a sample accepted in that cycle is discarded, and out_valid/out_data are unaffected.
REQ-025 SHALL, when SOME_MODULE_CLEAR_EN is undefined, have no clear port, with behaviour otherwise identical.

Verification
REQ-026 SHALL cover the test: SOME_BIT_PARAM=1, N=18 (OUT_W=13), 18 samples of 8'hFF with out_ready=1 -> one cycle later out_valid=1 and out_data=-18 (13'h1FEE).
REQ-027 SHALL cover the test: SOME_BIT_PARAM=0, N=18, 18 samples of 8'hFF -> out_data=4590 (13'h11EE); sample_cnt returns to 0.
REQ-028 SHALL cover the test: N=4 unsigned, samples 1,2,3,4 with out_ready=0 -> out_data=10 is held and in_ready=0; samples 5..8 are stalled; raising out_ready drains 10, then the next block gives 26.
REQ-029 SHALL cover the test: N=4 with a block completing while out_valid=1 and out_ready=1 -> back-to-back out_valid with no gap cycle.
REQ-030 SHALL cover the test: rst asserted after 2 of 4 samples (sum 7) -> after reset the next 4 samples of 1 give out_data=4.
REQ-031 SHALL cover the test: with SOME_MODULE_CLEAR_EN, clear after 3 samples -> sample_cnt=0 and the following block sum excludes the cleared samples.
